// File: rtl/wheel_speed_meas.sv
// Per-window wheel speed from free-running 16-bit edge counters, with a
// 2^AVG_LOG2-window moving average and a valid/ready output handshake.

module wheel_speed_lane #(
  parameter int          AVG_LOG2  = 2,
  parameter logic [15:0] MAX_DELTA = 16'd4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        tick,
  input  logic        upd,
  input  logic [15:0] edge_cnt,
  output logic [15:0] spd,
  output logic [15:0] avg,
  output logic        fault
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 16 + AVG_LOG2;

  logic [15:0]            prev, delta;
  logic [DEPTH-1:0][15:0] hist;
  logic [SW-1:0]          sum, sum_nxt;

  // sum always contains the oldest entry, so the subtraction cannot underflow
  assign sum_nxt = sum + SW'(delta) - SW'(hist[DEPTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= '0;
      delta <= '0;
      hist  <= '0;
      sum   <= '0;
      spd   <= '0;
      avg   <= '0;
      fault <= 1'b0;
    end else if (clr) begin
      prev <= '0;
      hist <= '0;
      sum  <= '0;
    end else begin
      if (tick) begin
        prev  <= edge_cnt;
        delta <= edge_cnt - prev;
      end
      if (upd) begin
        for (int i = DEPTH-1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= delta;
        sum     <= sum_nxt;
        spd     <= delta;
        avg     <= 16'(sum_nxt >> AVG_LOG2);
        fault   <= (delta > MAX_DELTA);
      end
    end
  end
endmodule

module wheel_speed_meas #(
  parameter int          WINDOW_CYC = 1250000,
  parameter int          AVG_LOG2   = 2,
  parameter logic [15:0] MAX_DELTA  = 16'd4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] edge_l,
  input  logic [15:0] edge_r,
  output logic [15:0] spd_l,
  output logic [15:0] spd_r,
  output logic [15:0] avg_l,
  output logic [15:0] avg_r,
  output logic        spd_valid,
  input  logic        spd_ready,
  output logic        fault_l,
  output logic        fault_r,
  output logic        overrun
);
  localparam int NUM_LANES = 2;
  localparam int WC_W      = $clog2(WINDOW_CYC);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                        state;
  logic [WC_W-1:0]               wc;
  logic                          tick, dlt_vld, upd;
  logic [NUM_LANES-1:0][15:0]    edge_cnt, spd_v, avg_v;
  logic [NUM_LANES-1:0]          fault_v;

  // a window that ends in the same cycle en drops is abandoned
  assign tick = (state != IDLE) && en && (wc == WC_LAST);
  assign upd  = dlt_vld && en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wc        <= '0;
      dlt_vld   <= 1'b0;
      spd_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      dlt_vld <= tick && (state == RUN);
      case (state)
        IDLE: begin
          wc <= '0;
          if (en) state <= PRIME;
        end
        default: begin
          if (!en) begin
            state <= IDLE;
            wc    <= '0;
          end else begin
            wc <= (wc == WC_LAST) ? '0 : wc + 1'b1;
            if (tick && state == PRIME) state <= RUN;
          end
        end
      endcase
      if (upd) begin
        spd_valid <= 1'b1;
        if (spd_valid && !spd_ready) overrun <= 1'b1;
      end else if (spd_valid && spd_ready) begin
        spd_valid <= 1'b0;
      end
    end
  end

  assign edge_cnt = {edge_r, edge_l};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    wheel_speed_lane #(
      .AVG_LOG2  (AVG_LOG2),
      .MAX_DELTA (MAX_DELTA)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (!en),
      .tick     (tick),
      .upd      (upd),
      .edge_cnt (edge_cnt[i]),
      .spd      (spd_v[i]),
      .avg      (avg_v[i]),
      .fault    (fault_v[i])
    );
  end

  assign spd_l   = spd_v[0];
  assign spd_r   = spd_v[1];
  assign avg_l   = avg_v[0];
  assign avg_r   = avg_v[1];
  assign fault_l = fault_v[0];
  assign fault_r = fault_v[1];
endmodule

// File: tb/tb_wheel_speed_meas.sv
// Directed + randomized bench for wheel_speed_meas against a per-window
// reference model (delta history queue, handshake bookkeeping).

module tb_wheel_speed_meas;
  localparam int W = 100;

  logic        clk = 1'b0;
  logic        rst, en, spd_ready;
  logic [15:0] edge_l, edge_r;
  logic [15:0] spd_l, spd_r, avg_l, avg_r;
  logic        spd_valid, fault_l, fault_r, overrun;

  wheel_speed_meas #(.WINDOW_CYC(W), .AVG_LOG2(2), .MAX_DELTA(16'd4000)) dut (
    .clk(clk), .rst(rst), .en(en), .edge_l(edge_l), .edge_r(edge_r),
    .spd_l(spd_l), .spd_r(spd_r), .avg_l(avg_l), .avg_r(avg_r),
    .spd_valid(spd_valid), .spd_ready(spd_ready),
    .fault_l(fault_l), .fault_r(fault_r), .overrun(overrun)
  );

  always #4 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: last four deltas per side plus expected output registers
  int          hl[$], hr[$];
  logic [15:0] m_spd_l, m_spd_r, m_avg_l, m_avg_r;
  logic        m_fault_l, m_fault_r, m_valid, m_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hist();
    hl = '{0, 0, 0, 0};
    hr = '{0, 0, 0, 0};
  endtask

  function automatic logic [15:0] mean4(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return 16'(s / 4);
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_spd_l"}, spd_l, m_spd_l);
    chk({tag, "_spd_r"}, spd_r, m_spd_r);
    chk({tag, "_avg_l"}, avg_l, m_avg_l);
    chk({tag, "_avg_r"}, avg_r, m_avg_r);
    chk({tag, "_fault_l"}, fault_l, m_fault_l);
    chk({tag, "_fault_r"}, fault_r, m_fault_r);
    chk({tag, "_valid"}, spd_valid, m_valid);
    chk({tag, "_overrun"}, overrun, m_ov);
  endtask

  // Enable from IDLE; returns one cycle after the priming latch edge.
  task automatic start();
    en = 1'b1;
    clear_hist();
    repeat (W + 2) cyc();
    chk("prime_valid", spd_valid, m_valid);
    chk("prime_spd_l", spd_l, m_spd_l);
    chk("prime_avg_r", avg_r, m_avg_r);
  endtask

  // One measurement window. Entered and left one cycle after a latch edge.
  // mode 0: ready low; 1: ready high all window; 2: ready only at the update edge.
  task automatic window(input string tag, input int dl, input int dr, input int mode);
    logic [15:0] d_l, d_r;
    d_l = 16'(dl);
    d_r = 16'(dr);
    edge_l = edge_l + d_l;
    edge_r = edge_r + d_r;
    spd_ready = (mode == 1);
    if (mode == 1) begin
      cyc();
      chk({tag, "_ack_drop"}, spd_valid, 1'b0);
      chk({tag, "_ack_ovr"}, overrun, m_ov);
      m_valid = 1'b0;
      repeat (W - 2) cyc();
    end else begin
      repeat (W - 1) cyc();
    end
    // latch edge just passed; the new sample must not be visible yet
    chk({tag, "_pre_valid"}, spd_valid, m_valid);
    chk({tag, "_pre_spd_l"}, spd_l, m_spd_l);
    if (mode == 2) spd_ready = 1'b1;
    if (m_valid && mode == 0) m_ov = 1'b1;
    hl.push_front(int'(d_l)); void'(hl.pop_back());
    hr.push_front(int'(d_r)); void'(hr.pop_back());
    m_spd_l = d_l;        m_spd_r = d_r;
    m_avg_l = mean4(hl);  m_avg_r = mean4(hr);
    m_fault_l = (d_l > 16'd4000);
    m_fault_r = (d_r > 16'd4000);
    m_valid = 1'b1;
    cyc();
    check_outputs(tag);
    spd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; spd_ready = 1'b0;
    edge_l = 16'($urandom); edge_r = 16'($urandom);
    m_spd_l = '0; m_spd_r = '0; m_avg_l = '0; m_avg_r = '0;
    m_fault_l = 1'b0; m_fault_r = 1'b0; m_valid = 1'b0; m_ov = 1'b0;
    clear_hist();
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    check_outputs("reset");

    // basic: constant 50 edges per window, avg ramps 12,25,37,50,50
    start();
    window("basic1", 50, 50, 1);
    chk("basic1_avg_const", avg_l, 16'd12);
    window("basic2", 50, 50, 2);
    chk("basic2_avg_const", avg_l, 16'd25);
    window("basic3", 50, 50, 2);
    window("basic4", 50, 50, 1);
    window("basic5", 50, 50, 2);
    chk("basic5_avg_const", avg_r, 16'd50);

    // wrap: prev = 0xFFF0, cur = 0x0010
    window("wrap_set", int'(16'hFFF0 - edge_l), int'(16'hFFF0 - edge_r), 1);
    window("wrap", 16'h20, 16'h20, 1);
    chk("wrap_spd_const", spd_l, 16'h0020);

    // fault on a single sample, cleared by the next normal one
    window("fault", 5000, 30, 1);
    chk("fault_flag_const", fault_l, 1'b1);
    window("fault_clr", 60, 60, 1);

    // handshake: unaccepted sample overwritten, then drain, then coincident accept
    window("ovr", 40, 41, 0);
    chk("ovr_const", overrun, 1'b1);
    window("drain", 45, 46, 1);
    window("hold", 47, 47, 0);
    window("coinc", 48, 49, 2);

    // disable mid-window: outputs hold, no samples
    repeat (30) cyc();
    en = 1'b0;
    repeat (2 * W) cyc();
    check_outputs("idle_hold");
    start();
    window("reen1", 70, 90, 1);
    window("reen2", 70, 90, 0);
    window("reen3", 70, 90, 1);

    for (int i = 0; i < 15; i++)
      window("rand", int'($urandom_range(0, 4200)), int'($urandom_range(0, 4200)),
             int'($urandom_range(0, 2)));

    // reset while a delta is in flight: nothing emerges
    edge_l = edge_l + 16'd100;
    edge_r = edge_r + 16'd100;
    repeat (W - 1) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_spd_l = '0; m_spd_r = '0; m_avg_l = '0; m_avg_r = '0;
    m_fault_l = 1'b0; m_fault_r = 1'b0; m_valid = 1'b0; m_ov = 1'b0;
    check_outputs("rst_pipe");
    repeat (5) cyc();
    chk("rst_pipe_late_valid", spd_valid, 1'b0);
    chk("rst_pipe_late_spd", spd_l, 16'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/wheel_speed_meas.md
# wheel_speed_meas

Converts the free-running 16-bit encoder edge counts produced by the left/right motor feedback counters into per-window wheel speeds plus a moving average, and hands them to the PS-side consumer over a valid/ready interface. Sits directly downstream of the feedback edge counters in the motor subsystem, in the 125 MHz `clk` domain. It replaces the PS's direct polling of the raw counters with time-aligned, wrap-safe speed samples.

## Interface
- `WINDOW_CYC`, 1250000: measurement window length in `clk` cycles (10 ms at 125 MHz); ≥ 4.
- `AVG_LOG2`, 2: moving average spans 2^AVG_LOG2 windows.
- `MAX_DELTA`, 16'd4000: plausibility limit for one window's edge delta.

- `clk`  in  1  system clock (125 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  measurement enable.
- `edge_l`, `edge_r`  in  16  free-running edge counts, left/right; they wrap modulo 2^16.
- `spd_l`, `spd_r`  out  16  edges in the last completed window.
- `avg_l`, `avg_r`  out  16  mean of the last 2^AVG_LOG2 window deltas.
- `spd_valid`  out  1  a new sample is available.
- `spd_ready`  in  1  consumer accepts the sample.
- `fault_l`, `fault_r`  out  1  delta of the current sample > MAX_DELTA.
- `overrun`  out  1  sticky: a sample was overwritten before acceptance.

One clock, `clk`. Reset `rst` is synchronous and active-high.

## Operation
- FSM states are IDLE, PRIME and RUN. Reset enters IDLE.
- IDLE: window counter `wc` is held at 0. Any `en`=1 moves the FSM to PRIME on the next cycle.
- PRIME/RUN: `wc` counts 0..WINDOW_CYC-1 and wraps. A tick occurs in the cycle where `wc`==WINDOW_CYC-1.
- Tick in PRIME: latch `edge_l`/`edge_r` into `prev_l`/`prev_r`, move to RUN, emit no sample.
- Tick in RUN:
  - Latch the current counts.
  - delta = (cur − prev) mod 2^16, per side.
  - Set prev ← cur.
  - Push delta into a 2^AVG_LOG2-deep history.
- Average: running sum of width 16+AVG_LOG2. On each push, sum ← sum + new − oldest. avg = sum >> AVG_LOG2.
  - History entries reset to 0, so the first samples are under-weighted until the history fills; this is intended.
- Fault: `fault_x` = (delta_x > MAX_DELTA). It is updated with every sample and is not sticky. `spd_x` carries the unmodified delta even when the fault is set.
- `en`=0 in PRIME or RUN returns the FSM to IDLE on the next cycle and clears `wc`, prev, history and sum. The output registers and `spd_valid` hold their values.
- Handshake:
  - A sample update sets `spd_valid`=1.
  - `spd_valid` && `spd_ready` in a cycle with no update clears `spd_valid` on the next cycle.
  - Update in a cycle where `spd_valid`=1 and `spd_ready`=0: data is overwritten, `spd_valid` stays 1, and `overrun` is set.
  - Update in a cycle where `spd_valid`=1 and `spd_ready`=1: the old sample counts as accepted, the new data loads, `spd_valid` stays 1, and `overrun` is unchanged.
- `overrun` is cleared only by `rst`.

## Timing
- Reset values: `spd_l`/`spd_r`/`avg_l`/`avg_r`=0, `spd_valid`=0, `fault_l`/`fault_r`=0, `overrun`=0. Internal state is also cleared: FSM=IDLE, `wc`=0, prev/history/sum=0.
- Tick at cycle T:
  - T+1: deltas registered.
  - T+2: `spd_*`, `avg_*` and `fault_*` are updated and `spd_valid` rises. Latency is 2 cycles.
  - The overrun and accept checks use `spd_valid`/`spd_ready` as sampled at the T+2 update edge.
- The first tick occurs WINDOW_CYC cycles after PRIME is entered. The first sample appears at the second tick + 2.
- Samples are spaced exactly WINDOW_CYC cycles apart while `en` stays high.
- `edge_*` inputs are sampled only at tick cycles. They are already synchronous to `clk`.
- `rst` asserted mid-window or mid-pipeline discards all in-flight work. No sample emerges after reset.

## Test plan
All scenarios use WINDOW_CYC=100, AVG_LOG2=2, MAX_DELTA=4000.

- Basic: after reset, `en`=1, edge counts increase by 50 per window → first `spd_valid` at the second tick + 2 with `spd`=50. `avg` sequence is 12, 25, 37, 50, 50.
- Wrap-around: prev=0xFFF0, cur=0x0010 → `spd`=0x0020, no fault.
- Fault: delta of 5000 in one window → `fault`=1 for that sample only. `spd`=5000. The next normal sample clears `fault`.
- Handshake: `spd_ready` held 0 across two samples → `overrun`=1, data shows the second sample. Assert `spd_ready` → `spd_valid` drops the next cycle, `overrun` stays 1. Accept coinciding with a new update → `spd_valid` stays 1, no new overrun.
- Disable/re-enable: `en`=0 mid-window → IDLE, outputs hold. Re-enable → one PRIME window with no output, then `avg` restarts from an empty history.
- Reset mid-pipeline: `rst` at T+1 after a tick → all outputs 0 and `spd_valid` never rises for that tick.
